// File: rtl/ber_pkg.sv
// Shared state type, width defaults, PRBS-7 constants and popcount helper for the BER test controller.
package ber_pkg;

  localparam int unsigned BER_SAMPLE_W  = 8;
  localparam int unsigned BER_LAT_W     = 6;
  localparam int unsigned BER_CNT_W     = 16;
  localparam int unsigned BER_POP_IN_W  = 32;
  localparam int unsigned BER_POP_OUT_W = 6;
  localparam int unsigned BER_PRBS_W    = 7;

  // x^7 + x^6 + 1: feedback from the two top stages
  localparam logic [BER_PRBS_W-1:0] BER_PRBS_POLY = 7'h60;
  localparam logic [BER_PRBS_W-1:0] BER_PRBS_SEED = 7'h7F;

  typedef enum logic [1:0] {
    BER_IDLE = 2'd0,
    BER_ARM  = 2'd1,
    BER_RUN  = 2'd2,
    BER_DONE = 2'd3
  } ber_state_e;

  function automatic logic [BER_POP_OUT_W-1:0] ber_popcount(input logic [BER_POP_IN_W-1:0] v);
    logic [BER_POP_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(BER_POP_IN_W); i++) begin
      n = n + BER_POP_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Tick-enabled sample shift register with a run-time tap; tap 0 passes the input straight through.
module sample_delay_line #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned LAT_W    = 6
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] din_i,
  input  logic [LAT_W-1:0]    tap_i,
  output logic [SAMPLE_W-1:0] dout_c
);

  localparam int unsigned DEPTH = (1 << LAT_W) - 1;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // mem_q[k] holds the sample from k+1 ticks ago
  always_comb begin
    dout_c = din_i;
    if (tap_i != '0) begin
      dout_c = mem_q[LAT_W'(tap_i - LAT_W'(1))];
    end
  end

endmodule

// File: rtl/ber_test_controller.sv
// BER test sequencer: arms the path select, waits out link latency, then accumulates bit errors over a window.
// Define BER_PRBS_EN to add an internal PRBS-7 stimulus source on prbs_sample.
module ber_test_controller
  import ber_pkg::*;
#(
  parameter int unsigned SAMPLE_W = BER_SAMPLE_W,
  parameter int unsigned LAT_W    = BER_LAT_W,
  parameter int unsigned CNT_W    = BER_CNT_W
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [CNT_W-1:0]    window_len,
  input  logic [LAT_W-1:0]    latency,
  input  logic [SAMPLE_W-1:0] tx_sample,
  input  logic [SAMPLE_W-1:0] rx_sample,
  output logic                path_sel,
  output logic                busy,
  output logic                done,
  output logic                saturated,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    sample_count
`ifdef BER_PRBS_EN
  ,
  output logic [SAMPLE_W-1:0] prbs_sample
`endif
);

  ber_state_e           state_q, state_d;
  logic                 path_q, path_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sat_q, sat_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [LAT_W-1:0]     arm_q, arm_d;
  logic [CNT_W-1:0]     win_q, win_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [CNT_W-1:0]     smp_q, smp_d;

  logic                 start_accept_c;
  logic [SAMPLE_W-1:0]  dl_din_c;
  logic [SAMPLE_W-1:0]  tx_delayed_c;
  logic [BER_POP_OUT_W-1:0] pop_c;
  logic [CNT_W:0]       err_sum_c;
  logic [CNT_W-1:0]     smp_inc_c;
  logic [LAT_W-1:0]     arm_inc_c;

  assign start_accept_c = start && !abort && ((state_q == BER_IDLE) || (state_q == BER_DONE));

  sample_delay_line #(
    .SAMPLE_W (SAMPLE_W),
    .LAT_W    (LAT_W)
  ) u_delay (
    .clk_i   (CLOCK_50),
    .reset_i (reset),
    .en_i    (sample_tick),
    .din_i   (dl_din_c),
    .tap_i   (lat_q),
    .dout_c  (tx_delayed_c)
  );

  assign pop_c     = ber_popcount(BER_POP_IN_W'(rx_sample ^ tx_delayed_c));
  assign err_sum_c = {1'b0, err_q} + (CNT_W+1)'(pop_c);
  assign smp_inc_c = smp_q + CNT_W'(1);
  assign arm_inc_c = arm_q + LAT_W'(1);

  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    sat_d   = sat_q;
    lat_d   = lat_q;
    arm_d   = arm_q;
    win_d   = win_q;
    err_d   = err_q;
    smp_d   = smp_q;
    case (state_q)
      BER_IDLE, BER_DONE: begin
        if (start_accept_c) begin
          state_d = BER_ARM;
          path_d  = mode;
          lat_d   = latency;
          win_d   = window_len;
          arm_d   = '0;
          err_d   = '0;
          smp_d   = '0;
          sat_d   = 1'b0;
        end
      end
      BER_ARM: begin
        // abort wins over everything; an empty window skips RUN entirely
        if (abort) begin
          state_d = BER_IDLE;
        end else if ((lat_q == '0) || (sample_tick && (arm_inc_c == lat_q))) begin
          state_d = (win_q == '0) ? BER_DONE : BER_RUN;
        end else if (sample_tick) begin
          arm_d = arm_inc_c;
        end
      end
      BER_RUN: begin
        if (abort) begin
          state_d = BER_IDLE;
        end else if (sample_tick) begin
          smp_d = smp_inc_c;
          if (err_sum_c[CNT_W]) begin
            err_d = '1;
            sat_d = 1'b1;
          end else begin
            err_d = err_sum_c[CNT_W-1:0];
          end
          if (smp_inc_c == win_q) begin
            state_d = BER_DONE;
          end
        end
      end
      default: state_d = BER_IDLE;
    endcase
    busy_d = (state_d == BER_ARM) || (state_d == BER_RUN);
    done_d = (state_d == BER_DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= BER_IDLE;
      path_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      lat_q   <= '0;
      arm_q   <= '0;
      win_q   <= '0;
      err_q   <= '0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      lat_q   <= lat_d;
      arm_q   <= arm_d;
      win_q   <= win_d;
      err_q   <= err_d;
      smp_q   <= smp_d;
    end
  end

`ifdef BER_PRBS_EN
  logic [BER_PRBS_W-1:0] lfsr_q, lfsr_d;
  logic [SAMPLE_W-1:0]   prbs_q, prbs_d;
  logic                  unused_tx;

  assign unused_tx = ^tx_sample;

  // SAMPLE_W LFSR steps per tick, first bit out lands in the MSB
  always_comb begin
    lfsr_d = lfsr_q;
    prbs_d = prbs_q;
    if (start_accept_c) begin
      lfsr_d = BER_PRBS_SEED;
    end else if (sample_tick) begin
      for (int i = 0; i < int'(SAMPLE_W); i++) begin
        prbs_d[SAMPLE_W-1-i] = ^(lfsr_d & BER_PRBS_POLY);
        lfsr_d = {lfsr_d[BER_PRBS_W-2:0], prbs_d[SAMPLE_W-1-i]};
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lfsr_q <= BER_PRBS_SEED;
      prbs_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      prbs_q <= prbs_d;
    end
  end

  assign dl_din_c    = prbs_q;
  assign prbs_sample = prbs_q;
`else
  assign dl_din_c = tx_sample;
`endif

  assign path_sel     = path_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign saturated    = sat_q;
  assign err_count    = err_q;
  assign sample_count = smp_q;

endmodule

// File: tb/tb_ber_test_controller.sv
// Randomized self-checking bench for ber_test_controller against a tick-history reference model.
module tb_ber_test_controller;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b1;
  logic [15:0] window_len = '0;
  logic [5:0]  latency = '0;
  logic [7:0]  tx_sample = '0;
  logic [7:0]  rx_sample = '0;
  logic        path_sel;
  logic        busy;
  logic        done;
  logic        saturated;
  logic [15:0] err_count;
  logic [15:0] sample_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] hist[$];

  always #10 CLOCK_50 = ~CLOCK_50;

  ber_test_controller dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .window_len   (window_len),
    .latency      (latency),
    .tx_sample    (tx_sample),
    .rx_sample    (rx_sample),
    .path_sel     (path_sel),
    .busy         (busy),
    .done         (done),
    .saturated    (saturated),
    .err_count    (err_count),
    .sample_count (sample_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_hist();
    hist.delete();
    for (int i = 0; i < 64; i++) hist.push_back(8'h00);
  endtask

  function automatic logic [7:0] make_rx(input int kind, input logic [7:0] txd);
    logic [7:0] r;
    case (kind)
      0:       r = txd;
      1:       r = txd ^ 8'h01;
      2:       r = ~txd;
      default: r = 8'($urandom);
    endcase
    return r;
  endfunction

  // one-cycle strobe; returns at the negedge after the consuming posedge
  task automatic do_tick(input logic [7:0] tx, input logic [7:0] rx);
    @(negedge CLOCK_50);
    sample_tick = 1'b1;
    tx_sample   = tx;
    rx_sample   = rx;
    @(negedge CLOCK_50);
    sample_tick = 1'b0;
  endtask

  task automatic idle_tick();
    logic [7:0] tx;
    tx = 8'($urandom);
    hist.push_back(tx);
    do_tick(tx, 8'($urandom));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_path"}, path_sel, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_sat"}, saturated, 0);
    check_eq({tag, "_err"}, err_count, 0);
    check_eq({tag, "_cnt"}, sample_count, 0);
  endtask

  // stop_kind: 0 = abort, 1 = reset, applied after RUN sample stop_at
  task automatic run_test(input logic m, input int lat, input int win, input int kind,
                          input int max_gap, input int stop_at, input int stop_kind,
                          input int restart_at);
    int         exp_err, exp_cnt, k;
    logic       exp_sat;
    logic [7:0] tx, txd, rx;
    exp_err = 0;
    exp_cnt = 0;
    exp_sat = 1'b0;
    mode       = m;
    latency    = 6'(lat);
    window_len = 16'(win);
    @(negedge CLOCK_50);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_path", path_sel, m);
    check_eq("start_done", done, 0);
    check_eq("start_err", err_count, 0);
    check_eq("start_cnt", sample_count, 0);
    check_eq("start_sat", saturated, 0);
    for (int j = 1; j <= lat + win; j++) begin
      tx = 8'($urandom);
      hist.push_back(tx);
      txd = hist[hist.size() - 1 - lat];
      if (j > lat) begin
        rx = make_rx(kind, txd);
        exp_err += $countones(rx ^ txd);
        if (exp_err > 65535) begin
          exp_err = 65535;
          exp_sat = 1'b1;
        end
        exp_cnt++;
      end else begin
        rx = 8'($urandom);
      end
      do_tick(tx, rx);
      if (j == lat + win - 1) check_eq("early_done", done, 0);
      if (stop_at != 0 && j == lat + stop_at) begin
        if (stop_kind == 0) begin
          abort = 1'b1;
          @(negedge CLOCK_50);
          abort = 1'b0;
          check_eq("abort_busy", busy, 0);
          check_eq("abort_done", done, 0);
          check_eq("abort_cnt", sample_count, exp_cnt);
          check_eq("abort_err", err_count, exp_err);
          repeat (3) idle_tick();
          check_eq("idle_cnt_hold", sample_count, exp_cnt);
          check_eq("idle_busy", busy, 0);
          mode  = ~m;
          start = 1'b1;
          abort = 1'b1;
          @(negedge CLOCK_50);
          start = 1'b0;
          abort = 1'b0;
          @(negedge CLOCK_50);
          check_eq("prio_busy", busy, 0);
          check_eq("prio_path", path_sel, m);
          check_eq("prio_cnt", sample_count, exp_cnt);
        end else begin
          reset = 1'b1;
          repeat (2) @(negedge CLOCK_50);
          reset = 1'b0;
          clear_hist();
          check_reset_state("midreset");
        end
        return;
      end
      if (restart_at != 0 && j == lat + restart_at) begin
        mode       = ~m;
        window_len = 16'd5;
        latency    = 6'd0;
        start      = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check_eq("restart_path", path_sel, m);
        check_eq("restart_busy", busy, 1);
        check_eq("restart_cnt", sample_count, exp_cnt);
      end
      repeat ($urandom_range(0, max_gap)) @(negedge CLOCK_50);
    end
    k = 0;
    while (done !== 1'b1 && k < 3) begin
      @(negedge CLOCK_50);
      k++;
    end
    check_eq("done_seen", done, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_path", path_sel, m);
    check_eq("end_err", err_count, exp_err);
    check_eq("end_cnt", sample_count, exp_cnt);
    check_eq("end_sat", saturated, exp_sat);
  endtask

  initial begin
    clear_hist();
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    check_reset_state("reset");

    run_test(1'b1, 3, 100, 0, 2, 0, 0, 0);
    run_test(1'b1, 3, 10, 1, 1, 0, 0, 0);
    check_eq("bit0_err", err_count, 10);
    run_test(1'b0, 4, 0, 3, 1, 0, 0, 0);
    run_test(1'b0, 0, 20, 3, 2, 0, 0, 0);
    run_test(1'b1, 2, 200, 3, 1, 50, 0, 0);
    check_eq("abort_cnt50", sample_count, 50);
    run_test(1'b0, 5, 30, 3, 1, 0, 0, 10);
    run_test(1'b1, 7, 9000, 2, 0, 0, 0, 0);
    check_eq("sat_err", err_count, 65535);
    check_eq("sat_flag", saturated, 1);
    check_eq("sat_cnt", sample_count, 9000);
    for (int r = 0; r < 6; r++) begin
      run_test(1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 40)),
               int'($urandom_range(0, 3)), 2, 0, 0, 0);
    end
    run_test(1'b0, 6, 50, 3, 1, 20, 1, 0);
    run_test(1'b1, 1, 8, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
